// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants for the mm:ss BCD countdown timer: FSM encoding and BCD limits.
package bcd_countdown_timer_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [15:0] BCD_ZERO     = 16'h0000;
    localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
    localparam logic [3:0]  DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/bcd_decrement_mmss.sv
// Combinational mm:ss BCD decrement with seconds wrap 00->59 and minute borrow,
// plus a digit range check (every digit <= 9, seconds tens <= 5).
module bcd_decrement_mmss
    import bcd_countdown_timer_pkg::*;
(
    input  logic [15:0] bcd_in,
    output logic [15:0] bcd_out,
    output logic        is_zero_next,
    output logic        valid_in
);

    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] digit_ok;

    assign min_tens = bcd_in[15:12];
    assign min_ones = bcd_in[11:8];
    assign sec_tens = bcd_in[7:4];
    assign sec_ones = bcd_in[3:0];

    // Per-digit range limit: only the seconds tens digit (index 1) stops at 5.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit_chk
            if (gi == 1) begin : g_sec_tens
                assign digit_ok[gi] = (bcd_in[gi*4 +: 4] <= SEC_TENS_MAX);
            end else begin : g_decimal
                assign digit_ok[gi] = (bcd_in[gi*4 +: 4] <= DIGIT_MAX);
            end
        end
    endgenerate

    assign valid_in = &digit_ok;

    // Borrow chain from seconds ones up to minutes tens; 0000 is never fed in by the top.
    always_comb begin
        bcd_out = bcd_in;
        if (sec_ones != 4'd0) begin
            bcd_out[3:0] = sec_ones - 4'd1;
        end else begin
            bcd_out[3:0] = DIGIT_MAX;
            if (sec_tens != 4'd0) begin
                bcd_out[7:4] = sec_tens - 4'd1;
            end else begin
                bcd_out[7:4] = SEC_TENS_MAX;
                if (min_ones != 4'd0) begin
                    bcd_out[11:8] = min_ones - 4'd1;
                end else begin
                    bcd_out[11:8]  = DIGIT_MAX;
                    bcd_out[15:12] = min_tens - 4'd1;
                end
            end
        end
    end

    assign is_zero_next = (bcd_out == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer: FSM, priority handling (clear > load > pause > start > tick),
// reload register and registered status outputs.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] time_out,
    output logic        running,
    output logic        expired,
    output logic        alarm,
    output logic        load_err
);

    logic [15:0] value_reg,    value_next;
    logic [15:0] reload_reg,   reload_next;
    state_t      state_reg,    state_next;
    logic        running_reg,  running_next;
    logic        expired_reg,  expired_next;
    logic        alarm_reg,    alarm_next;
    logic        load_err_reg, load_err_next;

    logic [15:0] dec_in;
    logic [15:0] dec_value;
    logic        dec_is_zero;
    logic        dec_valid;

    // One shared instance: on a load cycle only the range check matters (load outranks
    // tick), otherwise only the decrement result matters.
    assign dec_in = load ? load_value : value_reg;

    bcd_decrement_mmss u_dec (
        .bcd_in       (dec_in),
        .bcd_out      (dec_value),
        .is_zero_next (dec_is_zero),
        .valid_in     (dec_valid)
    );

    // Next-state and next-value selection in strict input priority order.
    always_comb begin
        value_next    = value_reg;
        reload_next   = reload_reg;
        state_next    = state_reg;
        expired_next  = 1'b0;
        load_err_next = 1'b0;

        if (clear) begin
            value_next = BCD_ZERO;
            state_next = ST_IDLE;
        end else if (load) begin
            if (dec_valid) begin
                value_next  = load_value;
                reload_next = load_value;
                state_next  = ST_IDLE;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (pause) begin
            if (state_reg == ST_RUN) begin
                state_next = ST_PAUSED;
            end
        end else if (start) begin
            if (((state_reg == ST_IDLE) || (state_reg == ST_PAUSED)) && (value_reg != BCD_ZERO)) begin
                state_next = ST_RUN;
            end
        end else if (tick_1hz && (state_reg == ST_RUN)) begin
            if (dec_is_zero) begin
                expired_next = 1'b1;
                if (AUTO_RELOAD && (reload_reg != BCD_ZERO)) begin
                    value_next = reload_reg;
                end else begin
                    value_next = BCD_ZERO;
                    state_next = ST_EXPIRED;
                end
            end else begin
                value_next = dec_value;
            end
        end

        running_next = (state_next == ST_RUN);
        alarm_next   = (state_next == ST_EXPIRED);
    end

    // State, value and status registers; reset returns everything to zero/IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg    <= BCD_ZERO;
            reload_reg   <= BCD_ZERO;
            state_reg    <= ST_IDLE;
            running_reg  <= 1'b0;
            expired_reg  <= 1'b0;
            alarm_reg    <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            value_reg    <= value_next;
            reload_reg   <= reload_next;
            state_reg    <= state_next;
            running_reg  <= running_next;
            expired_reg  <= expired_next;
            alarm_reg    <= alarm_next;
            load_err_reg <= load_err_next;
        end
    end

    assign time_out = value_reg;
    assign running  = running_reg;
    assign expired  = expired_reg;
    assign alarm    = alarm_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer: table-driven vectors, hand-written corner sequences
// and randomized stimulus, with one instance per AUTO_RELOAD setting and a
// seconds-count reference model.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;

    logic [15:0] time_out0, time_out1;
    logic        running0, running1, expired0, expired1;
    logic        alarm0, alarm1, load_err0, load_err1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .load(load),
        .load_value(load_value), .start(start), .pause(pause), .clear(clear),
        .time_out(time_out0), .running(running0), .expired(expired0),
        .alarm(alarm0), .load_err(load_err0)
    );

    bcd_countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .load(load),
        .load_value(load_value), .start(start), .pause(pause), .clear(clear),
        .time_out(time_out1), .running(running1), .expired(expired1),
        .alarm(alarm1), .load_err(load_err1)
    );

    // ---------------- reference model: time kept as total seconds ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mstate_e;

    int      m_secs   [2];
    int      m_reload [2];
    mstate_e m_st     [2];
    bit      m_exp    [2];
    bit      m_lerr   [2];

    function automatic int bcd2sec(input logic [15:0] b);
        return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] sec2bcd(input int s);
        int mm, ss;
        logic [15:0] r;
        mm = s / 60;
        ss = s % 60;
        r[15:12] = 4'(mm / 10);
        r[11:8]  = 4'(mm % 10);
        r[7:4]   = 4'(ss / 10);
        r[3:0]   = 4'(ss % 10);
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] b);
        return (b[15:12] < 10) && (b[11:8] < 10) && (b[7:4] < 6) && (b[3:0] < 10);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_secs[i] = 0; m_reload[i] = 0; m_st[i] = M_IDLE; m_exp[i] = 0; m_lerr[i] = 0;
        end
    endtask

    // Applies this cycle's inputs to model i (i is also its AUTO_RELOAD setting).
    task automatic model_update(input int i);
        m_exp[i] = 0;
        m_lerr[i] = 0;
        if (clear) begin
            m_secs[i] = 0;
            m_st[i] = M_IDLE;
        end else if (load) begin
            if (bcd_ok(load_value)) begin
                m_secs[i] = bcd2sec(load_value);
                m_reload[i] = m_secs[i];
                m_st[i] = M_IDLE;
            end else begin
                m_lerr[i] = 1;
            end
        end else if (pause) begin
            if (m_st[i] == M_RUN) m_st[i] = M_PAUSED;
        end else if (start) begin
            if ((m_st[i] == M_IDLE || m_st[i] == M_PAUSED) && m_secs[i] != 0) m_st[i] = M_RUN;
        end else if (tick_1hz && m_st[i] == M_RUN) begin
            m_secs[i] = m_secs[i] - 1;
            if (m_secs[i] == 0) begin
                m_exp[i] = 1;
                if (i == 1 && m_reload[i] != 0) m_secs[i] = m_reload[i];
                else m_st[i] = M_EXPIRED;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_models(input string tag);
        chk({tag, " d0 time"},  time_out0,        sec2bcd(m_secs[0]));
        chk({tag, " d0 run"},   16'(running0),    16'(m_st[0] == M_RUN));
        chk({tag, " d0 exp"},   16'(expired0),    16'(m_exp[0]));
        chk({tag, " d0 alarm"}, 16'(alarm0),      16'(m_st[0] == M_EXPIRED));
        chk({tag, " d0 lerr"},  16'(load_err0),   16'(m_lerr[0]));
        chk({tag, " d1 time"},  time_out1,        sec2bcd(m_secs[1]));
        chk({tag, " d1 run"},   16'(running1),    16'(m_st[1] == M_RUN));
        chk({tag, " d1 exp"},   16'(expired1),    16'(m_exp[1]));
        chk({tag, " d1 alarm"}, 16'(alarm1),      16'(m_st[1] == M_EXPIRED));
        chk({tag, " d1 lerr"},  16'(load_err1),   16'(m_lerr[1]));
    endtask

    // One clock cycle: drive inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic c, input logic l, input logic [15:0] lv,
                        input logic s, input logic p, input logic t, input string tag);
        clear = c; load = l; load_value = lv; start = s; pause = p; tick_1hz = t;
        model_update(0);
        model_update(1);
        @(posedge clk);
        #1;
        clear = 0; load = 0; start = 0; pause = 0; tick_1hz = 0;
        compare_models(tag);
        $display("step %-10s c=%b l=%b lv=%h s=%b p=%b t=%b | d0 %h r=%b e=%b a=%b le=%b | d1 %h r=%b e=%b a=%b",
                 tag, c, l, lv, s, p, t, time_out0, running0, expired0, alarm0, load_err0,
                 time_out1, running1, expired1, alarm1);
    endtask

    // ---------------- table of directed vectors (expectations for AUTO_RELOAD=0) ----------------
    typedef struct {
        logic        c, l;
        logic [15:0] lv;
        logic        s, p, t;
        logic [15:0] e_time;
        logic        e_run, e_exp, e_alarm, e_lerr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        //            c  l  lv        s  p  t  time      run exp alm lerr
        vecs.push_back('{0, 1, 16'h0102, 0, 0, 0, 16'h0102, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0102, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0101, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0100, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0059, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0959, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 16'h0070, 0, 0, 0, 16'h0959, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 16'h00A0, 0, 0, 0, 16'h0959, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 16'h0030, 0, 0, 0, 16'h0030, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0030, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 1, 1, 16'h0030, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 1, 16'h0030, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 1, 16'h0029, 1, 0, 0, 0});
    end

    // ---------------- main sequence ----------------
    initial begin
        int r;
        logic [15:0] lv;
        model_reset();
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        chk("reset d0 time", time_out0, 16'h0000);
        chk("reset d0 flags", {12'h0, running0, expired0, alarm0, load_err0}, 16'h0000);
        chk("reset d1 time", time_out1, 16'h0000);
        chk("reset d1 flags", {12'h0, running1, expired1, alarm1, load_err1}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table.
        for (int v = 0; v < vecs.size(); v++) begin
            step(vecs[v].c, vecs[v].l, vecs[v].lv, vecs[v].s, vecs[v].p, vecs[v].t, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d time", v), time_out0, vecs[v].e_time);
            chk($sformatf("vec%0d run", v),   16'(running0),  16'(vecs[v].e_run));
            chk($sformatf("vec%0d exp", v),   16'(expired0),  16'(vecs[v].e_exp));
            chk($sformatf("vec%0d alarm", v), 16'(alarm0),    16'(vecs[v].e_alarm));
            chk($sformatf("vec%0d lerr", v),  16'(load_err0), 16'(vecs[v].e_lerr));
        end

        // Auto-reload expiry: 0003 -> 0002, 0001, back to 0003 with an expired pulse.
        step(0, 1, 16'h0003, 0, 0, 0, "ar_load");
        step(0, 0, 16'h0000, 1, 0, 0, "ar_start");
        step(0, 0, 16'h0000, 0, 0, 1, "ar_t1");
        chk("ar t1 d1 time", time_out1, 16'h0002);
        step(0, 0, 16'h0000, 0, 0, 1, "ar_t2");
        chk("ar t2 d1 time", time_out1, 16'h0001);
        step(0, 0, 16'h0000, 0, 0, 1, "ar_t3");
        chk("ar t3 d1 time", time_out1, 16'h0003);
        chk("ar t3 d1 flags", {13'h0, running1, expired1, alarm1}, 16'h0006);
        chk("ar t3 d0 time", time_out0, 16'h0000);
        chk("ar t3 d0 flags", {13'h0, running0, expired0, alarm0}, 16'h0003);
        step(0, 0, 16'h0000, 0, 0, 1, "ar_t4");
        chk("ar t4 d1 time", time_out1, 16'h0002);
        chk("ar t4 d1 exp", 16'(expired1), 16'h0000);

        // Reset in the middle of a run at 05:45.
        step(0, 1, 16'h0546, 0, 0, 0, "rs_load");
        step(0, 0, 16'h0000, 1, 0, 0, "rs_start");
        step(0, 0, 16'h0000, 0, 0, 1, "rs_tick");
        chk("rs pre time", time_out0, 16'h0545);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rs async d0", {time_out0[11:0], running0, expired0, alarm0, load_err0}, 16'h0000);
        chk("rs async d0 hi", {12'h0, time_out0[15:12]}, 16'h0000);
        chk("rs async d1", {time_out1[11:0], running1, expired1, alarm1, load_err1}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 16'h0000, 1, 0, 1, "rs_start0");
        chk("start at zero running", 16'(running0), 16'h0000);
        step(0, 1, 16'h0000, 0, 0, 0, "ld_zero");
        step(0, 0, 16'h0000, 1, 0, 0, "st_zero");
        chk("start after 0000 load", {14'h0, running0, running1}, 16'h0000);

        // Randomized stimulus against the model: one control pulse per cycle at most.
        for (int n = 0; n < 600; n++) begin
            logic c, l, s, p, t;
            c = 0; l = 0; s = 0; p = 0;
            lv = 16'h0000;
            r = int'($urandom_range(0, 99));
            if (r < 3) c = 1;
            else if (r < 12) begin
                l = 1;
                if ($urandom_range(0, 9) < 7) lv = sec2bcd(int'($urandom_range(0, 5999)));
                else lv = 16'($urandom);
            end
            else if (r < 17) p = 1;
            else if (r < 27) s = 1;
            t = ($urandom_range(0, 99) < 40);
            step(c, l, lv, s, p, t, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
